// File: rtl/rr_fifo_arbiter_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rr_fifo_arbiter_pkg : shared helpers for the round-robin FIFO arbiter
// Rev 1.0
// ----------------------------------------------------------------------------
package rr_fifo_arbiter_pkg;

   // Ceiling log2 usable in constant expressions; clog2(1) = 0.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/rr_chan_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rr_chan_fifo : per-channel write FIFO with a combinational head output
// Rev 1.0
// ----------------------------------------------------------------------------
module rr_chan_fifo
   import rr_fifo_arbiter_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 8,
   localparam int ADDR_W = clog2(DEPTH),
   localparam int CNT_W  = clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic              pop,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] dout,
   output logic              empty,
   output logic              full
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              full_q, full_d;
   logic              do_push, do_pop;

   // Drop uses the full flag from the start of the cycle, so a same-cycle pop
   // never makes room for a write.
   assign do_push = push && !full_q;
   assign do_pop  = pop && (count_q != '0);

   always_comb begin
      wr_ptr_d = wr_ptr_q + ADDR_W'(do_push);
      rd_ptr_d = rd_ptr_q + ADDR_W'(do_pop);
      count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
      full_d   = (count_d == CNT_W'(DEPTH));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         full_q   <= full_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= din;
   end

   assign dout  = mem_q[rd_ptr_q];
   assign empty = (count_q == '0);
   assign full  = full_q;

endmodule
`default_nettype wire

// File: rtl/rr_fifo_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rr_fifo_arbiter : per-channel FIFOs drained by a work-conserving round-robin
//                   scheduler into one registered valid/ready output
// Rev 1.0
// ----------------------------------------------------------------------------
module rr_fifo_arbiter
   import rr_fifo_arbiter_pkg::*;
#(
   parameter int CH     = 4,
   parameter int DATA_W = 8,
   parameter int DEPTH  = 8,
   localparam int PTR_W = clog2(CH)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [CH-1:0]        wen,
   input  logic [CH*DATA_W-1:0] din,
   output logic [CH-1:0]        full,
   input  logic                 ready,
   output logic [DATA_W-1:0]    dout,
   output logic                 valid,
   output logic [PTR_W-1:0]     grant_id
);

   logic [CH-1:0]     empty;
   logic [CH-1:0]     pop;
   logic [DATA_W-1:0] head [CH];

   for (genvar i = 0; i < CH; i++) begin : g_chan
      rr_chan_fifo #(
         .DATA_W (DATA_W),
         .DEPTH  (DEPTH)
      ) u_fifo (
         .clk   (clk),
         .rst   (rst),
         .push  (wen[i]),
         .pop   (pop[i]),
         .din   (din[i*DATA_W +: DATA_W]),
         .dout  (head[i]),
         .empty (empty[i]),
         .full  (full[i])
      );
   end

   logic              valid_q, valid_d;
   logic [DATA_W-1:0] dout_q, dout_d;
   logic [PTR_W-1:0]  gid_q, gid_d;
   logic [PTR_W-1:0]  ptr_q, ptr_d;
   logic              load, found;
   logic [PTR_W-1:0]  winner, cand;
   int                idx;

   // First non-empty channel at or after ptr, wrapping modulo CH.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      idx    = 0;
      cand   = '0;
      for (int k = 0; k < CH; k++) begin
         idx = int'(ptr_q) + k;
         if (idx >= CH) idx = idx - CH;
         cand = PTR_W'(idx);
         if (!found && !empty[cand]) begin
            found  = 1'b1;
            winner = cand;
         end
      end
   end

   always_comb begin
      load    = !valid_q || ready;
      pop     = '0;
      valid_d = valid_q;
      dout_d  = dout_q;
      gid_d   = gid_q;
      ptr_d   = ptr_q;
      if (load) begin
         if (found) begin
            pop[winner] = 1'b1;
            dout_d      = head[winner];
            gid_d       = winner;
            valid_d     = 1'b1;
            ptr_d       = (winner == PTR_W'(CH - 1)) ? '0 : winner + PTR_W'(1);
         end else begin
            valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         dout_q  <= '0;
         gid_q   <= '0;
         ptr_q   <= '0;
      end else begin
         valid_q <= valid_d;
         dout_q  <= dout_d;
         gid_q   <= gid_d;
         ptr_q   <= ptr_d;
      end
   end

   assign valid    = valid_q;
   assign dout     = dout_q;
   assign grant_id = gid_q;

endmodule
`default_nettype wire

// File: tb/tb_rr_fifo_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_rr_fifo_arbiter : self-checking bench with a cycle-level reference model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_rr_fifo_arbiter;

   localparam int CH     = 4;
   localparam int DATA_W = 8;
   localparam int DEPTH  = 8;

   logic                 clk;
   logic                 rst;
   logic [CH-1:0]        wen;
   logic [CH*DATA_W-1:0] din;
   logic [CH-1:0]        full;
   logic                 ready;
   logic [DATA_W-1:0]    dout;
   logic                 valid;
   logic [1:0]           grant_id;

   rr_fifo_arbiter #(
      .CH     (CH),
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .wen      (wen),
      .din      (din),
      .full     (full),
      .ready    (ready),
      .dout     (dout),
      .valid    (valid),
      .grant_id (grant_id)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_en   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: per-channel scoreboard queues filled by accepted writes,
   // drained by the model's own round-robin choice.
   logic [DATA_W-1:0] mq [CH][$];
   logic              m_valid = 1'b0;
   logic [DATA_W-1:0] m_dout  = '0;
   logic [1:0]        m_gid   = '0;
   logic [CH-1:0]     m_full  = '0;
   int                m_ptr   = 0;
   bit                m_fl [CH];
   bit                m_ld;
   int                m_win;
   int                m_idx;

   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < CH; i++) mq[i].delete();
         m_valid = 1'b0;
         m_dout  = '0;
         m_gid   = '0;
         m_full  = '0;
         m_ptr   = 0;
      end else begin
         for (int i = 0; i < CH; i++) m_fl[i] = (mq[i].size() == DEPTH);
         m_ld  = !m_valid || ready;
         m_win = -1;
         if (m_ld) begin
            for (int k = 0; k < CH; k++) begin
               m_idx = (m_ptr + k) % CH;
               if (m_win < 0 && mq[m_idx].size() != 0) m_win = m_idx;
            end
            if (m_win >= 0) begin
               m_dout  = mq[m_win].pop_front();
               m_gid   = m_win[1:0];
               m_valid = 1'b1;
               m_ptr   = (m_win + 1) % CH;
            end else begin
               m_valid = 1'b0;
            end
         end
         for (int i = 0; i < CH; i++)
            if (wen[i] && !m_fl[i]) mq[i].push_back(din[i*DATA_W +: DATA_W]);
         for (int i = 0; i < CH; i++) m_full[i] = (mq[i].size() == DEPTH);
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("valid", {31'b0, valid}, {31'b0, m_valid});
         check("dout", {24'b0, dout}, {24'b0, m_dout});
         check("grant_id", {30'b0, grant_id}, {30'b0, m_gid});
         check("full", {28'b0, full}, {28'b0, m_full});
      end
   end

   task automatic cyc(input logic [CH-1:0] w, input logic [31:0] d, input logic r);
      @(negedge clk);
      wen   = w;
      din   = d;
      ready = r;
   endtask

   logic [DATA_W-1:0] got_q [$];
   bit                drained;

   // Collect every word accepted while ready=1 until the output goes idle.
   task automatic drain();
      got_q.delete();
      drained = 0;
      wen   = '0;
      ready = 1'b1;
      for (int t = 0; t < 80 && !drained; t++) begin
         if (valid) got_q.push_back(dout);
         else drained = 1;
         if (!drained) @(negedge clk);
      end
      check("drain_done", {31'b0, drained}, 32'd1);
   endtask

   logic [7:0] exp2 [4];
   int         rot_q [$];
   bit         hs_pend;
   int         hs_gid;
   logic [7:0] c;
   logic [7:0] v;

   initial begin
      rst   = 1'b1;
      wen   = '0;
      din   = '0;
      ready = 1'b0;
      repeat (2) @(negedge clk);
      chk_en = 1;
      check("por_valid", {31'b0, valid}, 32'd0);
      rst = 1'b0;

      // Mid-stream reset with data buffered and an unaccepted word on dout.
      cyc(4'hF, 32'h44332211, 1'b0);
      cyc(4'hF, 32'h88776655, 1'b0);
      cyc(4'h3, 32'h0000AA99, 1'b0);
      cyc(4'h0, 32'h0, 1'b0);
      check("pre_rst_valid", {31'b0, valid}, 32'd1);
      rst = 1'b1;
      cyc(4'h0, 32'h0, 1'b1);
      cyc(4'h0, 32'h0, 1'b1);
      rst = 1'b0;
      check("rst_valid", {31'b0, valid}, 32'd0);
      check("rst_dout", {24'b0, dout}, 32'd0);
      check("rst_full", {28'b0, full}, 32'd0);
      check("rst_gid", {30'b0, grant_id}, 32'd0);
      repeat (6) begin
         cyc(4'h0, 32'h0, 1'b1);
         check("post_rst_idle", {31'b0, valid}, 32'd0);
      end

      // One write per channel on a single edge drains in channel order.
      exp2[0] = 8'h10; exp2[1] = 8'h20; exp2[2] = 8'h30; exp2[3] = 8'h40;
      cyc(4'hF, 32'h40302010, 1'b1);
      cyc(4'h0, 32'h0, 1'b1);
      check("t2_latency", {31'b0, valid}, 32'd0);
      for (int j = 0; j < 4; j++) begin
         cyc(4'h0, 32'h0, 1'b1);
         check("t2_dout", {24'b0, dout}, {24'b0, exp2[j]});
         check("t2_gid", {30'b0, grant_id}, j);
      end
      cyc(4'h0, 32'h0, 1'b1);
      check("t2_idle", {31'b0, valid}, 32'd0);

      // Search wraps from ch3 back to ch2.
      cyc(4'h8, 32'h85000000, 1'b1);
      cyc(4'h4, 32'h00D90000, 1'b1);
      cyc(4'h0, 32'h0, 1'b1);
      check("t3_dout_a", {24'b0, dout}, 32'h85);
      check("t3_gid_a", {30'b0, grant_id}, 32'd3);
      cyc(4'h0, 32'h0, 1'b1);
      check("t3_dout_b", {24'b0, dout}, 32'hD9);
      check("t3_gid_b", {30'b0, grant_id}, 32'd2);
      cyc(4'h0, 32'h0, 1'b1);
      check("t3_idle", {31'b0, valid}, 32'd0);

      // Fill ch1 behind a stalled output; the tenth write is dropped.
      for (int k = 1; k <= 10; k++) begin
         v = 8'(k);
         cyc(4'h2, {16'h0, v, 8'h0}, 1'b0);
      end
      check("t4_full", {31'b0, full[1]}, 32'd1);
      check("t4_hold_dout", {24'b0, dout}, 32'd1);
      check("t4_hold_valid", {31'b0, valid}, 32'd1);
      cyc(4'h0, 32'h0, 1'b0);
      check("t4_still_full", {31'b0, full[1]}, 32'd1);
      drain();
      check("t4_count", got_q.size(), 32'd9);
      for (int k = 0; k < got_q.size() && k < 9; k++)
         check("t4_word", {24'b0, got_q[k]}, k + 1);

      // Saturated channels with a toggling consumer rotate strictly.
      hs_pend = 0;
      c = 8'h00;
      for (int t = 0; t < 80; t++) begin
         cyc(4'hF, {c + 8'd3, c + 8'd2, c + 8'd1, c}, 1'($urandom_range(0, 1)));
         if (hs_pend) rot_q.push_back(hs_gid);
         hs_pend = valid && ready;
         hs_gid  = int'(grant_id);
         c = c + 8'd4;
      end
      drain();
      check("t5_enough", {31'b0, rot_q.size() > 10}, 32'd1);
      for (int k = 1; k < rot_q.size(); k++)
         check("t5_rotate", rot_q[k], (rot_q[k-1] + 1) % CH);

      // Push and pop on ch0 in one cycle at count 3 keeps order.
      cyc(4'h1, 32'hA1, 1'b0);
      cyc(4'h1, 32'hA2, 1'b0);
      cyc(4'h1, 32'hA3, 1'b0);
      cyc(4'h1, 32'hA4, 1'b0);
      cyc(4'h1, 32'h51, 1'b1);
      check("t6_first", {24'b0, dout}, 32'hA1);
      cyc(4'h0, 32'h0, 1'b1);
      drain();
      check("t6_count", got_q.size(), 32'd4);
      if (got_q.size() == 4) begin
         check("t6_w0", {24'b0, got_q[0]}, 32'hA2);
         check("t6_w1", {24'b0, got_q[1]}, 32'hA3);
         check("t6_w2", {24'b0, got_q[2]}, 32'hA4);
         check("t6_w3", {24'b0, got_q[3]}, 32'h51);
      end

      // Random traffic, checked cycle by cycle against the model.
      for (int t = 0; t < 300; t++)
         cyc(4'($urandom_range(0, 15)), $urandom, 1'($urandom_range(0, 3) != 0));
      drain();

      cyc(4'h0, 32'h0, 1'b1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/rr_fifo_arbiter.md
# rr_fifo_arbiter

Parametrised round-robin arbiter with one write FIFO per channel. It is the generalised successor of the fixed 4-channel, 8-bit arbiter. Each channel buffers its writes in a private FIFO. A work-conserving round-robin scheduler drains the non-empty FIFOs into one registered output port with a valid/ready handshake. The block sits between independent producers and a single shared consumer (bus, display or serial link).

## Interface
- `CH`, 4, number of channels, ≥2.
- `DATA_W`, 8, data width per channel.
- `DEPTH`, 8, entries per channel FIFO, power of two, ≥2.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `wen`  in  CH  per-channel write enable.
- `din`  in  CH*DATA_W  channel i data on `din[i*DATA_W +: DATA_W]`.
- `full`  out  CH  per-channel FIFO full flag.
- `ready`  in  1  consumer accepts `dout` this cycle.
- `dout`  out  DATA_W  granted data word, registered.
- `valid`  out  1  `dout` holds a word not yet accepted.
- `grant_id`  out  $clog2(CH)  source channel of `dout`.

## Operation
- Reset (any cycle, including mid-transfer):
  - All FIFOs are emptied.
  - `full`=0, `valid`=0, `dout`=0, `grant_id`=0.
  - Round-robin pointer `ptr`=0.
  - In-flight data is discarded.
- Write:
  - If `wen[i]` is set and `full[i]`=0 at the edge, `din` slice i is pushed.
  - A write to a full FIFO is silently dropped, even if the same FIFO is popped in that cycle.
  - A pop frees space only from the next cycle onward.
- Output register load condition: `load = !valid || ready`.
  - If `load` is true and any FIFO is non-empty:
    - The winner is the first non-empty channel searching `ptr, ptr+1, …, CH-1, 0, …` (modulo CH).
    - Its head is popped into `dout` and `grant_id` is set to the winner.
    - `valid`=1 and `ptr` becomes winner+1 mod CH.
  - If `load` is true and all FIFOs are empty: `valid`=0, while `dout`, `grant_id` and `ptr` hold.
  - If `valid`=1 and `ready`=0: `dout`, `valid`, `grant_id` and `ptr` are frozen. No pop occurs.
- Non-emptiness used by the arbiter is the state at the start of the cycle. There is no write-to-output bypass.
- Simultaneous push and pop on the same FIFO are both honoured, and the count is unchanged (except the drop rule when full).
- Empty channels are skipped. The arbiter never spends a cycle on an empty channel.
- Fairness: a continuously non-empty channel waits at most CH-1 grants.

## Timing
- Write-to-output latency is 1 cycle minimum. A word pushed at edge E can appear on `dout` after edge E+1.
- Sustained throughput is one word per cycle while `ready`=1 and any FIFO is non-empty.
- `full[i]` is registered. It rises after the edge that makes count = DEPTH and falls after the edge that pops it.
- A handshake completes on an edge where `valid`=1 and `ready`=1. A new word may load on that same edge.

## Structure
- Shared package/header:
  - A `clog2` function.
  - Localparams `PTR_W = clog2(CH)` and `CNT_W = clog2(DEPTH)+1`.
  - No other typedefs.
- Sub-module `rr_chan_fifo`:
  - Parameters `DATA_W`, `DEPTH`.
  - Ports: `clk`, `rst`, `push`, `pop`, `din`, `dout` (head, combinational), `empty`, `full`.
  - Wrap-around read/write pointers plus a count.
  - Instantiated CH times in a generate loop.
- The top level holds the arbiter search, `ptr` and the output register.

## Test plan
All scenarios use CH=4, DATA_W=8, DEPTH=8.
1. Assert `rst` for 2 cycles mid-stream with data buffered → next cycle `valid`=0, `dout`=0, `full`=0000, `grant_id`=0. Prior data never appears afterwards.
2. With `ready`=1, write 10/20/30/40 to ch0–3 on one edge → `dout` = 10, 20, 30, 40 on four consecutive cycles, with `grant_id` = 0, 1, 2, 3. Then `valid`=0.
3. With `ptr`=0, write ch3 = 0x85, then ch2 = 0xD9 on the next edge → `dout` = 0x85 (`grant_id`=3), then 0xD9 (`grant_id`=2) after the search wraps.
4. With `ready`=0, write 1..10 to ch1 on consecutive edges → `dout`=1 held with `valid`=1, and `full[1]`=1 after the 9th write. Value 10 is dropped. With `ready`=1, the output is 1..9 then `valid`=0.
5. Keep all channels refilled every cycle (`wen`=1111) → grants strictly rotate 0, 1, 2, 3, 0, …. Toggling `ready` never repeats or skips a word.
6. Write ch0 = 0x51 while pop and push hit ch0 in the same cycle at count 3 → count stays 3 and FIFO order is preserved.
